spi_txn_ctrl: RTL and testbench

Transaction controller that shares one byte-wide SPI master engine between two requesters. It round-robin arbitrates, drives a per-requester active-low chip select, and sequences 1–8 byte transfers through the engine's start/busy handshake. Each received byte is returned to the owning requester. It sits between the game/peripheral logic and the SPI byte engine, and owns the chip selects.

---
 rtl/spi_txn_ctrl.sv | 158 +++++++++++++++
 tb/tb_spi_txn_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_ctrl.sv
// spi_txn_ctrl: shares one byte-wide SPI engine between two requesters.
// Round-robin grant, owner-only active-low chip select, and 1..8 byte
// transfers sequenced through the engine's start/busy handshake.
module spi_txn_ctrl #(
    parameter int unsigned CS_SETUP     = 4,
    parameter int unsigned CS_HOLD      = 4,
    parameter int unsigned INTER_BYTE   = 2,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [2:0] len0,
    input  logic [2:0] len1,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    output logic [1:0] gnt,
    output logic [1:0] tx_next,
    output logic [1:0] rx_valid,
    output logic [7:0] rx_data,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic [1:0] cs_n,
    output logic       spi_start,
    output logic [7:0] spi_data_in,
    input  logic       spi_busy,
    input  logic [7:0] spi_data_out
);

    // Terminal values of the shared phase timer. GAP and HOLD are entered in
    // the same cycle rx_valid shows, so they run one cycle longer than the
    // nominal count to land spi_start/done INTER_BYTE+1 / CS_HOLD+1 cycles
    // after rx_valid.
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] GAP_LAST   = 8'(INTER_BYTE);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD);
    localparam logic [7:0] BUSY_LAST  = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, LOAD, WAIT_BUSY, WAIT_DONE, GAP, HOLD, FINISH
    } state_t;

    state_t     state;
    logic [7:0] tmr;
    logic [3:0] bytes_left;
    logic       owner;
    logic       last_owner;

    // Arbitration choice and decoded length for the requester about to win.
    logic       pick;
    logic [2:0] pick_len_raw;
    logic [3:0] pick_len;

    assign pick         = (req == 2'b11) ? ~last_owner : req[1];
    assign pick_len_raw = pick ? len1 : len0;
    assign pick_len     = (pick_len_raw == 3'd0) ? 4'd8 : {1'b0, pick_len_raw};

    // Transaction sequencer; every output is a register updated here. Pulses
    // are set on the edge entering the state that owns them, so each one is
    // visible for exactly that state's single cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tmr         <= 8'd0;
            bytes_left  <= 4'd0;
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            gnt         <= 2'b00;
            cs_n        <= 2'b11;
            tx_next     <= 2'b00;
            rx_valid    <= 2'b00;
            rx_data     <= 8'h00;
            done        <= 2'b00;
            err         <= 2'b00;
            spi_start   <= 1'b0;
            spi_data_in <= 8'h00;
        end else begin
            spi_start <= 1'b0;
            tx_next   <= 2'b00;
            rx_valid  <= 2'b00;
            done      <= 2'b00;
            err       <= 2'b00;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner      <= pick;
                        gnt        <= pick ? 2'b10 : 2'b01;
                        cs_n       <= pick ? 2'b01 : 2'b10;
                        bytes_left <= pick_len;
                        tmr        <= 8'd0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (tmr == SETUP_LAST) begin
                        state          <= LOAD;
                        spi_start      <= 1'b1;
                        tx_next[owner] <= 1'b1;
                        spi_data_in    <= owner ? tx1 : tx0;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end
                LOAD: begin
                    tmr   <= 8'd0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (spi_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmr == BUSY_LAST) begin
                        // Engine never answered: abort, release the slave.
                        state      <= FINISH;
                        cs_n       <= 2'b11;
                        gnt        <= 2'b00;
                        err[owner] <= 1'b1;
                        last_owner <= owner;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!spi_busy) begin
                        rx_data         <= spi_data_out;
                        rx_valid[owner] <= 1'b1;
                        bytes_left      <= bytes_left - 4'd1;
                        tmr             <= 8'd0;
                        state           <= (bytes_left == 4'd1) ? HOLD : GAP;
                    end
                end
                GAP: begin
                    if (tmr == GAP_LAST) begin
                        state          <= LOAD;
                        spi_start      <= 1'b1;
                        tx_next[owner] <= 1'b1;
                        spi_data_in    <= owner ? tx1 : tx0;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end
                HOLD: begin
                    if (tmr == HOLD_LAST) begin
                        state       <= FINISH;
                        cs_n        <= 2'b11;
                        gnt         <= 2'b00;
                        done[owner] <= 1'b1;
                        last_owner  <= owner;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Bench for spi_txn_ctrl: loopback engine model, event monitor, and
// scenario tasks checked against timing rules computed from event times.
module tb_spi_txn_ctrl;
    localparam int CS = 4;
    localparam int CH = 4;
    localparam int IB = 2;
    localparam int BT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [2:0] len0, len1;
    logic [7:0] tx0, tx1;
    logic [1:0] gnt, tx_next, rx_valid, done, err, cs_n;
    logic [7:0] rx_data, spi_data_in, spi_data_out;
    logic       spi_start, spi_busy;

    spi_txn_ctrl #(.CS_SETUP(CS), .CS_HOLD(CH), .INTER_BYTE(IB), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1), .tx0(tx0), .tx1(tx1),
        .gnt(gnt), .tx_next(tx_next), .rx_valid(rx_valid), .rx_data(rx_data),
        .done(done), .err(err), .cs_n(cs_n), .spi_start(spi_start),
        .spi_data_in(spi_data_in), .spi_busy(spi_busy), .spi_data_out(spi_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int m_last = 1;

    // Per-requester byte streams; tx is advanced on each tx_next.
    logic [7:0] str0 [256];
    logic [7:0] str1 [256];
    int p0 = 0, p1 = 0;

    logic eng_en = 1'b1;
    int   eng_dur = 0;

    int         st_cyc[$];
    int         rx_cyc[$];
    logic [7:0] rx_dat[$];
    logic [1:0] rx_own[$];
    int         end_cyc[$];
    logic [1:0] end_done[$], end_err[$], end_csn[$];
    int         gnt_cyc[$];
    logic [1:0] gnt_val[$], gnt_csn[$];
    int         fall_cyc[$];
    int         viol = 0;

    // Requester side: present the next stream byte after each tx_next.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_next[0]) p0++;
            if (tx_next[1]) p1++;
            tx0 = str0[p0 % 256];
            tx1 = str1[p1 % 256];
        end
    end

    // Byte engine: loops spi_data_in back after a random latency/duration.
    initial begin
        spi_busy = 1'b0;
        spi_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (eng_en && spi_start === 1'b1) begin
                logic [7:0] d;
                int lat, dur;
                d   = spi_data_in;
                lat = $urandom_range(0, 2);
                dur = (eng_dur != 0) ? eng_dur : $urandom_range(2, 5);
                repeat (lat) @(negedge clk);
                spi_busy = 1'b1;
                repeat (dur) @(negedge clk);
                spi_busy = 1'b0;
                spi_data_out = d;
                fall_cyc.push_back(cyc);
            end
        end
    end

    // Event monitor sampling just after each active edge.
    initial begin
        logic [1:0] prev_gnt;
        prev_gnt = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (spi_start === 1'b1) st_cyc.push_back(cyc);
            if (rx_valid != 2'b00) begin
                rx_cyc.push_back(cyc); rx_dat.push_back(rx_data); rx_own.push_back(rx_valid);
            end
            if (done != 2'b00 || err != 2'b00) begin
                end_cyc.push_back(cyc); end_done.push_back(done);
                end_err.push_back(err); end_csn.push_back(cs_n);
            end
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                gnt_cyc.push_back(cyc); gnt_val.push_back(gnt); gnt_csn.push_back(cs_n);
            end
            prev_gnt = gnt;
            if (cs_n !== ~gnt || cs_n === 2'b00 || (rx_valid & ~gnt) != 2'b00 ||
                (tx_next & ~gnt) != 2'b00 || $countones(done | err) > 1)
                viol++;
        end
    end

    task automatic wait_gnt(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (gnt_cyc.size() >= target) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_ends(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (end_cyc.size() >= target) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b00; len0 = 3'd0; len1 = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if (cs_n !== 2'b11) begin errors++; $display("FAIL reset_cs_n got=%b exp=11", cs_n); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        checks++; if ({spi_start, tx_next, rx_valid, done, err} !== 9'd0) begin
            errors++; $display("FAIL reset_pulses got=%b exp=0", {spi_start, tx_next, rx_valid, done, err}); end
        checks++; if (rx_data !== 8'h00 || spi_data_in !== 8'h00) begin
            errors++; $display("FAIL reset_data got=%h/%h exp=00/00", rx_data, spi_data_in); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (gnt !== 2'b00 || cs_n !== 2'b11) begin
            errors++; $display("FAIL idle_no_req got=%b/%b exp=00/11", gnt, cs_n); end
    endtask

    task automatic test_single();
        int gb, sb, rb, eb, fb, q0, c, g;
        bit ok;
        gb = gnt_cyc.size(); sb = st_cyc.size(); rb = rx_cyc.size();
        eb = end_cyc.size(); fb = fall_cyc.size();
        str0[p0 % 256] = 8'hA5;
        repeat (2) @(negedge clk);
        q0 = p0; len0 = 3'd1; req = 2'b01; c = cyc;
        wait_gnt(gb + 1, 5, ok);
        req = 2'b00;
        checks++; if (!ok) begin errors++; $display("FAIL single_gnt got=none exp=grant"); return; end
        g = gnt_cyc[gb];
        checks++; if (g != c + 1 || gnt_val[gb] !== 2'b01 || gnt_csn[gb] !== 2'b10) begin
            errors++; $display("FAIL single_grant got=cyc%0d %b %b exp=cyc%0d 01 10", g, gnt_val[gb], gnt_csn[gb], c + 1); end
        wait_ends(eb + 1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_end got=none exp=done"); return; end
        checks++; if (st_cyc.size() - sb != 1 || st_cyc[sb] != g + CS) begin
            errors++; $display("FAIL single_start got=n%0d exp=1 at %0d", st_cyc.size() - sb, g + CS); end
        checks++; if (p0 - q0 != 1) begin errors++; $display("FAIL single_txnext got=%0d exp=1", p0 - q0); end
        checks++; if (rx_cyc.size() - rb != 1 || fall_cyc.size() - fb != 1) begin
            errors++; $display("FAIL single_rx_count got=%0d exp=1", rx_cyc.size() - rb); return; end
        checks++; if (rx_dat[rb] !== 8'hA5 || rx_own[rb] !== 2'b01 || rx_cyc[rb] != fall_cyc[fb] + 1) begin
            errors++; $display("FAIL single_rx got=%h %b cyc%0d exp=a5 01 cyc%0d", rx_dat[rb], rx_own[rb], rx_cyc[rb], fall_cyc[fb] + 1); end
        checks++; if (end_done[eb] !== 2'b01 || end_err[eb] !== 2'b00 || end_csn[eb] !== 2'b11 ||
                      end_cyc[eb] != rx_cyc[rb] + CH + 1) begin
            errors++; $display("FAIL single_done got=%b %b %b cyc%0d exp=01 00 11 cyc%0d",
                               end_done[eb], end_err[eb], end_csn[eb], end_cyc[eb], rx_cyc[rb] + CH + 1); end
        m_last = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_burst();
        int gb, sb, rb, eb, fb, q1, g, v0, es;
        bit ok;
        gb = gnt_cyc.size(); sb = st_cyc.size(); rb = rx_cyc.size();
        eb = end_cyc.size(); fb = fall_cyc.size(); v0 = viol;
        for (int i = 0; i < 8; i++) str1[(p1 + i) % 256] = 8'(i + 1);
        repeat (2) @(negedge clk);
        q1 = p1; len1 = 3'd0; req = 2'b10;
        wait_gnt(gb + 1, 5, ok);
        req = 2'b00;
        checks++; if (!ok) begin errors++; $display("FAIL burst_gnt got=none exp=grant"); return; end
        g = gnt_cyc[gb];
        checks++; if (gnt_val[gb] !== 2'b10) begin errors++; $display("FAIL burst_owner got=%b exp=10", gnt_val[gb]); end
        wait_ends(eb + 1, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_end got=none exp=done"); return; end
        checks++; if (st_cyc.size() - sb != 8 || rx_cyc.size() - rb != 8 || fall_cyc.size() - fb < 8 || p1 - q1 != 8) begin
            errors++; $display("FAIL burst_counts got=st%0d rx%0d tn%0d exp=8", st_cyc.size() - sb, rx_cyc.size() - rb, p1 - q1);
            return; end
        for (int i = 0; i < 8; i++) begin
            es = (i == 0) ? g + CS : rx_cyc[rb + i - 1] + IB + 1;
            checks++; if (st_cyc[sb + i] != es) begin
                errors++; $display("FAIL burst_start%0d got=cyc%0d exp=cyc%0d", i, st_cyc[sb + i], es); end
            checks++; if (rx_dat[rb + i] !== 8'(i + 1) || rx_own[rb + i] !== 2'b10 || rx_cyc[rb + i] != fall_cyc[fb + i] + 1) begin
                errors++; $display("FAIL burst_rx%0d got=%h %b exp=%h 10", i, rx_dat[rb + i], rx_own[rb + i], 8'(i + 1)); end
        end
        checks++; if (end_done[eb] !== 2'b10 || end_cyc[eb] != rx_cyc[rb + 7] + CH + 1) begin
            errors++; $display("FAIL burst_done got=%b cyc%0d exp=10 cyc%0d", end_done[eb], end_cyc[eb], rx_cyc[rb + 7] + CH + 1); end
        checks++; if (gnt_cyc.size() - gb != 1 || viol != v0) begin
            errors++; $display("FAIL burst_cs_held got=grants%0d viol%0d exp=1 0", gnt_cyc.size() - gb, viol - v0); end
        m_last = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_arb();
        int gb, eb, v0, own;
        bit ok;
        logic [1:0] ob;
        gb = gnt_cyc.size(); eb = end_cyc.size(); v0 = viol;
        len0 = 3'($urandom_range(1, 2)); len1 = 3'($urandom_range(1, 2));
        req = 2'b11;
        wait_ends(eb + 3, 600, ok);
        req = 2'b00;
        checks++; if (!ok) begin errors++; $display("FAIL arb_end got=%0d exp=3", end_cyc.size() - eb); return; end
        repeat (4) @(negedge clk);
        checks++; if (gnt_cyc.size() - gb != 3) begin
            errors++; $display("FAIL arb_grants got=%0d exp=3", gnt_cyc.size() - gb); return; end
        own = 1 - m_last;
        for (int k = 0; k < 3; k++) begin
            ob = own ? 2'b10 : 2'b01;
            checks++; if (gnt_val[gb + k] !== ob || end_done[eb + k] !== ob || end_err[eb + k] !== 2'b00) begin
                errors++; $display("FAIL arb_order%0d got=%b/%b exp=%b", k, gnt_val[gb + k], end_done[eb + k], ob); end
            if (k > 0) begin
                checks++; if (gnt_cyc[gb + k] != end_cyc[eb + k - 1] + 2) begin
                    errors++; $display("FAIL arb_idle_gap%0d got=cyc%0d exp=cyc%0d", k, gnt_cyc[gb + k], end_cyc[eb + k - 1] + 2); end
            end
            m_last = own;
            own = 1 - own;
        end
        checks++; if (viol != v0) begin errors++; $display("FAIL arb_cs_n got=viol%0d exp=0", viol - v0); end
    endtask

    task automatic test_timeout();
        int gb, sb, rb, eb;
        bit ok;
        gb = gnt_cyc.size(); sb = st_cyc.size(); rb = rx_cyc.size(); eb = end_cyc.size();
        eng_en = 1'b0; len1 = 3'd2; req = 2'b10;
        wait_gnt(gb + 1, 5, ok);
        req = 2'b00;
        wait_ends(eb + 1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_end got=none exp=err"); eng_en = 1'b1; return; end
        checks++; if (st_cyc.size() - sb != 1 || rx_cyc.size() - rb != 0) begin
            errors++; $display("FAIL timeout_counts got=st%0d rx%0d exp=1 0", st_cyc.size() - sb, rx_cyc.size() - rb); end
        checks++; if (end_err[eb] !== 2'b10 || end_done[eb] !== 2'b00 || end_csn[eb] !== 2'b11) begin
            errors++; $display("FAIL timeout_err got=%b %b %b exp=10 00 11", end_err[eb], end_done[eb], end_csn[eb]); end
        if (st_cyc.size() - sb >= 1) begin
            checks++; if (end_cyc[eb] != st_cyc[sb] + BT + 1) begin
                errors++; $display("FAIL timeout_time got=cyc%0d exp=cyc%0d", end_cyc[eb], st_cyc[sb] + BT + 1); end
        end
        m_last = 1; eng_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int gb, sb, rb, eb, q0, c;
        bit ok;
        gb = gnt_cyc.size(); sb = st_cyc.size(); eb = end_cyc.size();
        eng_dur = 8; len0 = 3'd4; req = 2'b01;
        wait_gnt(gb + 1, 5, ok);
        req = 2'b00;
        for (int i = 0; i < 200 && st_cyc.size() < sb + 2; i++) @(negedge clk);
        checks++; if (st_cyc.size() < sb + 2) begin errors++; $display("FAIL rmid_byte2 got=none exp=start"); end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (cs_n !== 2'b11 || gnt !== 2'b00 || {spi_start, tx_next, rx_valid, done, err} !== 9'd0 ||
                      rx_data !== 8'h00 || spi_data_in !== 8'h00) begin
            errors++; $display("FAIL rmid_reset got=cs%b g%b p%b rx%h sd%h exp=11 00 0 00 00",
                               cs_n, gnt, {spi_start, tx_next, rx_valid, done, err}, rx_data, spi_data_in); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; eng_dur = 0; m_last = 1;
        for (int i = 0; i < 20 && spi_busy; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++; if (end_cyc.size() != eb) begin errors++; $display("FAIL rmid_no_end got=%0d exp=0", end_cyc.size() - eb); end
        gb = gnt_cyc.size(); rb = rx_cyc.size(); eb = end_cyc.size();
        q0 = p0; len0 = 3'd1; req = 2'b01; c = cyc;
        wait_gnt(gb + 1, 5, ok);
        req = 2'b00;
        checks++; if (!ok || gnt_cyc[gb] != c + 1 || gnt_val[gb] !== 2'b01) begin
            errors++; $display("FAIL rmid_restart_gnt got=%0d exp=grant 01 at cyc%0d", ok, c + 1); return; end
        wait_ends(eb + 1, 200, ok);
        checks++; if (!ok || end_done[eb] !== 2'b01 || rx_cyc.size() - rb != 1) begin
            errors++; $display("FAIL rmid_restart_done got=%0d exp=done 01", ok); return; end
        checks++; if (rx_dat[rb] !== str0[q0 % 256]) begin
            errors++; $display("FAIL rmid_restart_rx got=%h exp=%h", rx_dat[rb], str0[q0 % 256]); end
        m_last = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_req_drop();
        int gb, rb, eb, q0;
        bit ok;
        gb = gnt_cyc.size(); rb = rx_cyc.size(); eb = end_cyc.size();
        q0 = p0; len0 = 3'd3; req = 2'b01;
        for (int i = 0; i < 50 && p0 == q0; i++) @(negedge clk);
        req = 2'b00;
        wait_ends(eb + 1, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_end got=none exp=done"); return; end
        repeat (4) @(negedge clk);
        checks++; if (rx_cyc.size() - rb != 3 || end_done[eb] !== 2'b01 || gnt_cyc.size() - gb != 1) begin
            errors++; $display("FAIL drop_txn got=rx%0d done%b grants%0d exp=3 01 1",
                               rx_cyc.size() - rb, end_done[eb], gnt_cyc.size() - gb); return; end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rx_dat[rb + i] !== str0[(q0 + i) % 256]) begin
                errors++; $display("FAIL drop_rx%0d got=%h exp=%h", i, rx_dat[rb + i], str0[(q0 + i) % 256]); end
        end
        m_last = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int r, own, n, gb, sb, rb, eb, fb, q, c, g, es;
            bit ok;
            logic [2:0] l0, l1;
            logic [1:0] ob;
            logic [7:0] ed;
            r  = $urandom_range(1, 3);
            l0 = 3'($urandom_range(0, 7));
            l1 = 3'($urandom_range(0, 7));
            own = (r == 3) ? 1 - m_last : ((r == 2) ? 1 : 0);
            n   = own ? ((l1 == 3'd0) ? 8 : int'(l1)) : ((l0 == 3'd0) ? 8 : int'(l0));
            ob  = own ? 2'b10 : 2'b01;
            q   = own ? p1 : p0;
            gb = gnt_cyc.size(); sb = st_cyc.size(); rb = rx_cyc.size();
            eb = end_cyc.size(); fb = fall_cyc.size();
            len0 = l0; len1 = l1; req = 2'(r); c = cyc;
            wait_gnt(gb + 1, 5, ok);
            req = 2'b00;
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_gnt got=none exp=grant", it); return; end
            g = gnt_cyc[gb];
            checks++; if (g != c + 1 || gnt_val[gb] !== ob) begin
                errors++; $display("FAIL rnd%0d_grant got=%b cyc%0d exp=%b cyc%0d", it, gnt_val[gb], g, ob, c + 1); end
            wait_ends(eb + 1, 600, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_end got=none exp=done", it); return; end
            checks++; if (st_cyc.size() - sb != n || rx_cyc.size() - rb != n || fall_cyc.size() - fb < n) begin
                errors++; $display("FAIL rnd%0d_counts got=st%0d rx%0d exp=%0d", it, st_cyc.size() - sb, rx_cyc.size() - rb, n);
                return; end
            for (int i = 0; i < n; i++) begin
                es = (i == 0) ? g + CS : rx_cyc[rb + i - 1] + IB + 1;
                ed = own ? str1[(q + i) % 256] : str0[(q + i) % 256];
                checks++; if (st_cyc[sb + i] != es || rx_cyc[rb + i] != fall_cyc[fb + i] + 1) begin
                    errors++; $display("FAIL rnd%0d_time%0d got=st%0d rx%0d exp=st%0d rx%0d",
                                       it, i, st_cyc[sb + i], rx_cyc[rb + i], es, fall_cyc[fb + i] + 1); end
                checks++; if (rx_dat[rb + i] !== ed || rx_own[rb + i] !== ob) begin
                    errors++; $display("FAIL rnd%0d_rx%0d got=%h %b exp=%h %b", it, i, rx_dat[rb + i], rx_own[rb + i], ed, ob); end
            end
            checks++; if (end_done[eb] !== ob || end_err[eb] !== 2'b00 || end_csn[eb] !== 2'b11 ||
                          end_cyc[eb] != rx_cyc[rb + n - 1] + CH + 1) begin
                errors++; $display("FAIL rnd%0d_done got=%b %b cyc%0d exp=%b 00 cyc%0d",
                                   it, end_done[eb], end_err[eb], end_cyc[eb], ob, rx_cyc[rb + n - 1] + CH + 1); end
            m_last = own;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            str0[i] = 8'($urandom);
            str1[i] = 8'($urandom);
        end
        test_reset();
        test_single();
        test_burst();
        test_arb();
        test_timeout();
        test_reset_mid();
        test_req_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
